// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: ARM condition evaluation, flag-write sequencing, flag RAW stall/bypass and branch squash
module cond_exec_ctrl #(
  parameter bit FLAG_BYPASS = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic             id_b,
  input  logic [3:0]       exe_flags,
  output logic             id_exec,
  output logic             flag_stall,
  output logic             branch_taken,
  output logic [3:0]       sr,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] annul_cnt
);
  logic pend, squash, cond_pass, needs_flags, issue, live;
  logic [3:0] f;
  always_comb begin
    f = (FLAG_BYPASS && pend) ? exe_flags : sr;
    cond_pass = 1'b0;
    case (id_cond)
      4'b0000: cond_pass = f[2];
      4'b0001: cond_pass = !f[2];
      4'b0010: cond_pass = f[1];
      4'b0011: cond_pass = !f[1];
      4'b0100: cond_pass = f[3];
      4'b0101: cond_pass = !f[3];
      4'b0110: cond_pass = f[0];
      4'b0111: cond_pass = !f[0];
      4'b1000: cond_pass = f[1] & !f[2];
      4'b1001: cond_pass = !f[1] | f[2];
      4'b1010: cond_pass = f[3] == f[0];
      4'b1011: cond_pass = f[3] != f[0];
      4'b1100: cond_pass = !f[2] & (f[3] == f[0]);
      4'b1101: cond_pass = f[2] | (f[3] != f[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
  assign needs_flags = id_cond[3:1] != 3'b111;
  // a squashed wrong-path instruction never stalls
  assign live = rst & ~freeze & id_valid & ~squash;
  assign flag_stall = live & pend & needs_flags & ~FLAG_BYPASS;
  assign issue = live & ~flag_stall;
  assign id_exec = issue & cond_pass;
  assign branch_taken = id_exec & id_b;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
      pend <= 1'b0;
      squash <= 1'b0;
      exec_cnt <= '0;
      annul_cnt <= '0;
    end else if (!freeze) begin
      if (pend) sr <= exe_flags;
      pend <= id_exec & id_s;
      squash <= branch_taken;
      exec_cnt <= exec_cnt + CNT_W'(id_exec);
      annul_cnt <= annul_cnt + CNT_W'((issue & ~cond_pass) | (squash & id_valid));
    end
  end
endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb_cond_exec_ctrl: stall (u0) and bypass (u1) instances on shared stimulus, scoreboarded against a reference model
module tb_cond_exec_ctrl;
  localparam logic [3:0] EQ = 4'h0, AL = 4'hE, NV = 4'hF;
  logic clk = 1'b0;
  logic rst, freeze, id_valid, id_s, id_b;
  logic [3:0] id_cond, exe_flags;
  logic ex0, st0, bt0, ex1, st1, bt1;
  logic [3:0] sr0, ec0, ac0, sr1, ec1, ac1;
  typedef struct {logic ex, st, bt; logic [3:0] sr, ec, ac;} exp_t;
  exp_t sbq[$];
  logic [3:0] m_sr[2], m_ec[2], m_ac[2];
  logic m_pend[2], m_sq[2];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  cond_exec_ctrl #(.FLAG_BYPASS(1'b0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_cond(id_cond),
    .id_s(id_s), .id_b(id_b), .exe_flags(exe_flags), .id_exec(ex0), .flag_stall(st0),
    .branch_taken(bt0), .sr(sr0), .exec_cnt(ec0), .annul_cnt(ac0));
  cond_exec_ctrl #(.FLAG_BYPASS(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .freeze(freeze), .id_valid(id_valid), .id_cond(id_cond),
    .id_s(id_s), .id_b(id_b), .exe_flags(exe_flags), .id_exec(ex1), .flag_stall(st1),
    .branch_taken(bt1), .sr(sr1), .exec_cnt(ec1), .annul_cnt(ac1));
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  // ARM idiom: odd codes invert the even code below them
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
    logic n, z, k, v, r;
    {n, z, k, v} = fl;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = k;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = k & !z;
      3'd5: r = n == v;
      3'd6: r = !z & (n == v);
      default: r = 1'b1;
    endcase
    return r ^ c[0];
  endfunction
  task automatic cyc(input logic r, input logic f, input logic v, input logic [3:0] c,
                     input logic s, input logic b, input logic [3:0] e);
    exp_t x;
    logic st, iss, cp;
    @(posedge clk);
    #1;
    rst = r; freeze = f; id_valid = v; id_cond = c; id_s = s; id_b = b; exe_flags = e;
    for (int d = 0; d < 2; d++) begin
      cp = cond_ok(c, (d == 1 && m_pend[d]) ? e : m_sr[d]);
      st = r & !f & v & !m_sq[d] & m_pend[d] & (c < 4'd14) & (d == 0);
      iss = r & !f & v & !m_sq[d] & !st;
      x.ex = iss & cp; x.st = st; x.bt = iss & cp & b;
      x.sr = m_sr[d]; x.ec = m_ec[d]; x.ac = m_ac[d];
      sbq.push_back(x);
      if (!r) begin
        m_sr[d] = '0; m_ec[d] = '0; m_ac[d] = '0; m_pend[d] = 1'b0; m_sq[d] = 1'b0;
      end else if (!f) begin
        if (m_pend[d]) m_sr[d] = e;
        m_ac[d] = m_ac[d] + 4'((iss & !cp) | (m_sq[d] & v));
        m_ec[d] = m_ec[d] + 4'(x.ex);
        m_pend[d] = x.ex & s;
        m_sq[d] = x.bt;
      end
    end
    @(negedge clk);
    x = sbq.pop_front();
    chk("u0.id_exec", 4'(ex0), 4'(x.ex)); chk("u0.flag_stall", 4'(st0), 4'(x.st));
    chk("u0.branch_taken", 4'(bt0), 4'(x.bt)); chk("u0.sr", sr0, x.sr);
    chk("u0.exec_cnt", ec0, x.ec); chk("u0.annul_cnt", ac0, x.ac);
    x = sbq.pop_front();
    chk("u1.id_exec", 4'(ex1), 4'(x.ex)); chk("u1.flag_stall", 4'(st1), 4'(x.st));
    chk("u1.branch_taken", 4'(bt1), 4'(x.bt)); chk("u1.sr", sr1, x.sr);
    chk("u1.exec_cnt", ec1, x.ec); chk("u1.annul_cnt", ac1, x.ac);
  endtask
  initial begin
    logic r, f;
    logic [3:0] e;
    rst = 1'b0; freeze = 1'b0; id_valid = 1'b0; id_cond = AL; id_s = 1'b0; id_b = 1'b0; exe_flags = '0;
    for (int d = 0; d < 2; d++) begin
      m_sr[d] = '0; m_ec[d] = '0; m_ac[d] = '0; m_pend[d] = 1'b0; m_sq[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    // reset holds AL off, then it issues
    repeat (2) cyc(0, 0, 1, AL, 0, 0, 4'h0);
    chk("rst_exec", 4'(ex0), 4'h0); chk("rst_sr", sr0, 4'h0); chk("rst_ec", ec0, 4'h0); chk("rst_ac", ac0, 4'h0);
    cyc(1, 0, 1, AL, 0, 0, 4'h0);
    chk("post_rst_exec", 4'(ex0), 4'h1);
    // stall path on u0
    cyc(0, 0, 0, AL, 0, 0, 4'h0);
    cyc(1, 0, 1, AL, 1, 0, 4'h0);
    chk("stall_c1_exec", 4'(ex0), 4'h1);
    cyc(1, 0, 1, EQ, 0, 1, 4'h4);
    chk("stall_c2_stall", 4'(st0), 4'h1); chk("stall_c2_exec", 4'(ex0), 4'h0);
    chk("bypass_c2_stall", 4'(st1), 4'h0); chk("bypass_c2_exec", 4'(ex1), 4'h1); chk("bypass_c2_bt", 4'(bt1), 4'h1);
    cyc(1, 0, 1, EQ, 0, 1, 4'h4);
    chk("stall_c3_sr", sr0, 4'h4); chk("stall_c3_exec", 4'(ex0), 4'h1); chk("stall_c3_bt", 4'(bt0), 4'h1);
    chk("bypass_c3_sr", sr1, 4'h4);
    cyc(1, 0, 1, AL, 0, 0, 4'h0);
    chk("stall_c4_exec", 4'(ex0), 4'h0);
    cyc(1, 0, 0, AL, 0, 0, 4'h0);
    chk("stall_annul", ac0, 4'h1); chk("stall_exec_cnt", ec0, 4'h2);
    // bypass path on u1 with a valid wrong-path instruction
    cyc(0, 0, 0, AL, 0, 0, 4'h0);
    cyc(1, 0, 1, AL, 1, 0, 4'h0);
    cyc(1, 0, 1, EQ, 0, 1, 4'h4);
    chk("byp_c2_exec", 4'(ex1), 4'h1); chk("byp_c2_bt", 4'(bt1), 4'h1);
    cyc(1, 0, 1, AL, 0, 0, 4'h0);
    chk("byp_sr", sr1, 4'h4); chk("byp_squash_exec", 4'(ex1), 4'h0);
    // full condition sweep; exe_flags inverted so a stray bypass shows up
    for (int sv = 0; sv < 16; sv++) begin
      cyc(1, 0, 1, AL, 1, 0, 4'(sv));
      cyc(1, 0, 0, AL, 0, 0, 4'(sv));
      for (int c = 0; c < 16; c++) begin
        cyc(1, 0, 1, 4'(c), 0, 0, ~4'(sv));
        if (sv == 2 && c == 9) chk("ls_sr0010", 4'(ex0), 4'h0);
        if (sv == 2 && c == 8) chk("hi_sr0010", 4'(ex0), 4'h1);
        if (sv == 8 && c == 13) chk("le_sr1000", 4'(ex0), 4'h1);
        if (sv == 8 && c == 12) chk("gt_sr1000", 4'(ex0), 4'h0);
        if (c == 15) chk("nv_never", 4'(ex1), 4'h0);
      end
    end
    // freeze over a pending write
    cyc(0, 0, 0, AL, 0, 0, 4'h0);
    cyc(1, 0, 1, AL, 1, 0, 4'h9);
    repeat (3) begin
      cyc(1, 1, 1, AL, 0, 0, 4'h9);
      chk("frz_sr", sr0, 4'h0); chk("frz_exec", 4'(ex0), 4'h0); chk("frz_exec_byp", 4'(ex1), 4'h0);
    end
    cyc(1, 0, 0, AL, 0, 0, 4'h9);
    chk("frz_rel_sr_old", sr0, 4'h0);
    cyc(1, 0, 0, AL, 0, 0, 4'h9);
    chk("frz_rel_sr", sr0, 4'h9); chk("frz_rel_sr_byp", sr1, 4'h9);
    // counter wrap
    cyc(0, 0, 0, AL, 0, 0, 4'h0);
    repeat (16) cyc(1, 0, 1, AL, 0, 0, 4'h0);
    cyc(1, 0, 1, NV, 0, 0, 4'h0);
    cyc(1, 0, 0, AL, 0, 0, 4'h0);
    chk("wrap_exec_cnt", ec0, 4'h0); chk("wrap_annul_cnt", ac0, 4'h1);
    // random traffic; exe_flags held across freezes
    e = '0;
    repeat (400) begin
      r = $urandom_range(0, 40) != 0;
      f = $urandom_range(0, 5) == 0;
      if (!f) e = 4'($urandom);
      cyc(r, f, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), e);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
